// File: rtl/notch_coef_ctrl.sv
// rtl/notch_coef_ctrl.sv - shadow/active coefficient bank with sample-aligned swap, clear and settle bypass
module notch_coef_ctrl #(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] B0     = 16'h4000,
    parameter logic [WIDTH-1:0] B1     = 16'h678E,
    parameter logic [WIDTH-1:0] B2     = 16'h4000,
    parameter logic [WIDTH-1:0] A1     = 16'h6473,
    parameter logic [WIDTH-1:0] A2     = 16'h3C38,
    parameter int               SETTLE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             smp_valid,
    input  logic             cfg_wr,
    input  logic [2:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_commit,
    output logic             cfg_busy,
    output logic             cfg_err,
    output logic             commit_done,
    output logic [WIDTH-1:0] coef_b0,
    output logic [WIDTH-1:0] coef_b1,
    output logic [WIDTH-1:0] coef_b2,
    output logic [WIDTH-1:0] coef_a1,
    output logic [WIDTH-1:0] coef_a2,
    output logic             filt_clr,
    output logic             bypass
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_CLEAR,
        ST_SETTLE
    } state_t;

    // Settle length as an 8-bit terminal count for the sample counter.
    localparam logic [7:0] SETTLE_N = 8'(SETTLE);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q  [5];
    logic [WIDTH-1:0] sh_d  [5];
    logic [WIDTH-1:0] act_q [5];
    logic [WIDTH-1:0] act_d [5];
    logic [7:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             clr_q, clr_d;
    logic             byp_q, byp_d;

    // Next-state logic: shadow writes in IDLE, swap on the first sample in PEND,
    // one-cycle clear, then count samples in bypass until the new response settles.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        clr_d   = 1'b0;
        byp_d   = byp_q;

        case (state_q)
            ST_IDLE: begin
                // The write is applied before the commit so a same-cycle write joins it.
                if (cfg_wr) begin
                    case (cfg_addr)
                        3'd0:    sh_d[0] = cfg_data;
                        3'd1:    sh_d[1] = cfg_data;
                        3'd2:    sh_d[2] = cfg_data;
                        3'd3:    sh_d[3] = cfg_data;
                        3'd4:    sh_d[4] = cfg_data;
                        default: ;
                    endcase
                end
                if (cfg_commit) begin
                    state_d = ST_PEND;
                    busy_d  = 1'b1;
                end
            end
            ST_PEND: begin
                // The strobed sample still uses the old bank; the swap lands on its edge.
                if (smp_valid) begin
                    act_d   = sh_q;
                    state_d = ST_CLEAR;
                    clr_d   = 1'b1;
                    byp_d   = 1'b1;
                end
            end
            ST_CLEAR: begin
                // A sample arriving here is deliberately not counted.
                cnt_d = 8'd0;
                if (SETTLE_N != 8'd0) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                    byp_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (smp_valid) begin
                    if (cnt_q + 8'd1 == SETTLE_N) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                        byp_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any host request while busy is dropped and flagged one cycle later.
        if ((cfg_wr || cfg_commit) && busy_q) begin
            err_d = 1'b1;
        end
    end

    // State and registered outputs; reset restores the parameter coefficients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sh_q[0]  <= B0;
            sh_q[1]  <= B1;
            sh_q[2]  <= B2;
            sh_q[3]  <= A1;
            sh_q[4]  <= A2;
            act_q[0] <= B0;
            act_q[1] <= B1;
            act_q[2] <= B2;
            act_q[3] <= A1;
            act_q[4] <= A2;
            cnt_q    <= 8'd0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            clr_q    <= 1'b0;
            byp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            byp_q   <= byp_d;
        end
    end

    assign cfg_busy    = busy_q;
    assign cfg_err     = err_q;
    assign commit_done = done_q;
    assign filt_clr    = clr_q;
    assign bypass      = byp_q;
    assign coef_b0     = act_q[0];
    assign coef_b1     = act_q[1];
    assign coef_b2     = act_q[2];
    assign coef_a1     = act_q[3];
    assign coef_a2     = act_q[4];

endmodule

// File: tb/tb_notch_coef_ctrl.sv
// tb/tb_notch_coef_ctrl.sv - self-checking bench for notch_coef_ctrl
module tb_notch_coef_ctrl;

    localparam int ST = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        smp_valid = 1'b0, cfg_wr = 1'b0, cfg_commit = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [15:0] cfg_data = 16'd0;
    logic        cfg_busy, cfg_err, commit_done, filt_clr, bypass;
    logic [15:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;

    logic        z_smp_valid = 1'b0, z_cfg_wr = 1'b0, z_cfg_commit = 1'b0;
    logic [2:0]  z_cfg_addr = 3'd0;
    logic [15:0] z_cfg_data = 16'd0;
    logic        z_cfg_busy, z_cfg_err, z_commit_done, z_filt_clr, z_bypass;
    logic [15:0] z_coef_b0, z_coef_b1, z_coef_b2, z_coef_a1, z_coef_a2;

    notch_coef_ctrl #(.WIDTH(16), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n), .smp_valid(smp_valid),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err), .commit_done(commit_done),
        .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_b2(coef_b2),
        .coef_a1(coef_a1), .coef_a2(coef_a2),
        .filt_clr(filt_clr), .bypass(bypass)
    );

    notch_coef_ctrl #(.WIDTH(16), .SETTLE(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .smp_valid(z_smp_valid),
        .cfg_wr(z_cfg_wr), .cfg_addr(z_cfg_addr), .cfg_data(z_cfg_data), .cfg_commit(z_cfg_commit),
        .cfg_busy(z_cfg_busy), .cfg_err(z_cfg_err), .commit_done(z_commit_done),
        .coef_b0(z_coef_b0), .coef_b1(z_coef_b1), .coef_b2(z_coef_b2),
        .coef_a1(z_coef_a1), .coef_a2(z_coef_a2),
        .filt_clr(z_filt_clr), .bypass(z_bypass)
    );

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] sh [5];
    logic [15:0] ac [5];

    function automatic logic [15:0] rst_val(input int i);
        case (i)
            0:       return 16'h4000;
            1:       return 16'h678E;
            2:       return 16'h4000;
            3:       return 16'h6473;
            default: return 16'h3C38;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            sh[i] = rst_val(i);
            ac[i] = rst_val(i);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_active(input string tag);
        logic [15:0] o [5];
        o[0] = coef_b0; o[1] = coef_b1; o[2] = coef_b2; o[3] = coef_a1; o[4] = coef_a2;
        for (int i = 0; i < 5; i++) chk($sformatf("%s[%0d]", tag, i), 32'(o[i]), 32'(ac[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_wr = 1'b0;
        if (a < 3'd5) sh[a] = d;
        chk("wr_err", 32'(cfg_err), 0);
        chk("wr_busy", 32'(cfg_busy), 0);
    endtask

    // One full commit on the SETTLE=8 instance. same_a >= 0 adds a same-cycle write,
    // per < 0 randomizes strobe spacing, abort_at > 0 resets before that counted strobe.
    task automatic run_commit(input int nwr, input int same_a, input logic [15:0] same_d,
                              input int gap0, input int per, input bit inj,
                              input bit clrstb, input int abort_at);
        int g;
        for (int i = 0; i < nwr; i++) wr(3'($urandom_range(0, 7)), 16'($urandom));
        cfg_commit = 1'b1;
        if (same_a >= 0) begin
            cfg_wr = 1'b1; cfg_addr = 3'(same_a); cfg_data = same_d;
            sh[same_a] = same_d;
        end
        tick();
        cfg_commit = 1'b0; cfg_wr = 1'b0;
        chk("busy_rise", 32'(cfg_busy), 1);
        chk("commit_err", 32'(cfg_err), 0);
        chk_active("pend_coef");
        for (int i = 0; i < gap0; i++) begin
            tick();
            chk("pend_bypass", 32'(bypass), 0);
            chk("pend_clr", 32'(filt_clr), 0);
        end
        chk_active("pend_hold");
        smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
        for (int i = 0; i < 5; i++) ac[i] = sh[i];
        chk_active("swap");
        chk("clr_high", 32'(filt_clr), 1);
        chk("bypass_clear", 32'(bypass), 1);
        smp_valid = clrstb;
        tick();
        smp_valid = 1'b0;
        chk("clr_low", 32'(filt_clr), 0);
        chk("bypass_settle", 32'(bypass), 1);
        chk("busy_settle", 32'(cfg_busy), 1);
        for (int k = 1; k <= ST; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #2;
                model_reset();
                chk_active("async_rst_coef");
                chk("async_rst_bypass", 32'(bypass), 0);
                chk("async_rst_busy", 32'(cfg_busy), 0);
                chk("async_rst_clr", 32'(filt_clr), 0);
                tick(); tick();
                rst_n = 1'b1;
                tick();
                chk_active("post_rst_coef");
                chk("post_rst_busy", 32'(cfg_busy), 0);
                return;
            end
            if (inj && k == 3) begin
                cfg_wr = 1'b1; cfg_addr = 3'd1; cfg_data = 16'h1111;
                tick();
                cfg_wr = 1'b0;
                chk("rej_wr_err", 32'(cfg_err), 1);
                tick();
                chk("rej_wr_err_end", 32'(cfg_err), 0);
                cfg_commit = 1'b1;
                tick();
                cfg_commit = 1'b0;
                chk("rej_cm_err", 32'(cfg_err), 1);
                chk_active("rej_coef");
                tick();
                chk("rej_cm_err_end", 32'(cfg_err), 0);
            end
            g = (per < 0) ? int'($urandom_range(0, 3)) : per - 1;
            for (int j = 0; j < g; j++) begin
                tick();
                chk("settle_gap_bypass", 32'(bypass), 1);
                chk("settle_gap_done", 32'(commit_done), 0);
            end
            smp_valid = 1'b1;
            tick();
            smp_valid = 1'b0;
            if (k < ST) begin
                chk("settle_bypass", 32'(bypass), 1);
                chk("settle_busy", 32'(cfg_busy), 1);
                chk("settle_done", 32'(commit_done), 0);
            end else begin
                chk("final_bypass", 32'(bypass), 0);
                chk("final_busy", 32'(cfg_busy), 0);
                chk("final_done", 32'(commit_done), 1);
            end
        end
        tick();
        chk("done_pulse_end", 32'(commit_done), 0);
        chk_active("idle_coef");
    endtask

    // Commit on the SETTLE=0 instance: clear and bypass for one cycle, done right after.
    task automatic run_zero(input logic [15:0] d, input int gap);
        z_cfg_wr = 1'b1; z_cfg_addr = 3'd0; z_cfg_data = d; z_cfg_commit = 1'b1;
        tick();
        z_cfg_wr = 1'b0; z_cfg_commit = 1'b0;
        chk("z_busy", 32'(z_cfg_busy), 1);
        for (int i = 0; i < gap; i++) tick();
        z_smp_valid = 1'b1;
        tick();
        z_smp_valid = 1'b0;
        chk("z_clr", 32'(z_filt_clr), 1);
        chk("z_bypass", 32'(z_bypass), 1);
        chk("z_coef_b0", 32'(z_coef_b0), 32'(d));
        tick();
        chk("z_clr_low", 32'(z_filt_clr), 0);
        chk("z_bypass_low", 32'(z_bypass), 0);
        chk("z_done", 32'(z_commit_done), 1);
        chk("z_busy_low", 32'(z_cfg_busy), 0);
        tick();
        chk("z_done_end", 32'(z_commit_done), 0);
    endtask

    initial begin
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk_active("reset_coef");
        chk("reset_bypass", 32'(bypass), 0);
        chk("reset_busy", 32'(cfg_busy), 0);
        chk("reset_clr", 32'(filt_clr), 0);
        chk("reset_done", 32'(commit_done), 0);
        chk("reset_err", 32'(cfg_err), 0);
        chk("z_reset_b0", 32'(z_coef_b0), 32'h4000);

        wr(3'd3, 16'h5000);
        run_commit(0, -1, 16'h0, 4, 4, 1'b0, 1'b0, 0);
        chk("a1_5000", 32'(coef_a1), 32'h5000);

        run_commit(0, 0, 16'h2000, 1, -1, 1'b0, 1'b1, 0);
        chk("b0_2000", 32'(coef_b0), 32'h2000);

        run_commit(0, -1, 16'h0, 0, -1, 1'b1, 1'b0, 0);
        run_commit(0, -1, 16'h0, 2, 1, 1'b0, 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            run_commit(int'($urandom_range(0, 4)),
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1,
                       16'($urandom), int'($urandom_range(0, 5)), -1,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        run_zero(16'h1234, 0);
        run_zero(16'($urandom), int'($urandom_range(1, 4)));

        wr(3'd4, 16'h0100);
        run_commit(0, -1, 16'h0, 2, -1, 1'b0, 1'b0, 4);
        chk("a2_restored", 32'(coef_a2), 32'h3C38);
        chk("z_b0_restored", 32'(z_coef_b0), 32'h4000);

        run_commit(2, -1, 16'h0, 1, -1, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/notch_coef_ctrl.md
# notch_coef_ctrl

Runtime coefficient controller for the 16-bit IIR notch biquad (`top`). A host loads new B0/B1/B2/A1/A2 values into a shadow bank, then commits them. The controller swaps the active coefficients only at a sample boundary, clears the filter state, and holds the filter in bypass for a programmable number of samples while the new response settles. It sits between the register/host side and the biquad coefficient inputs; its outputs replace the biquad's compile-time coefficient parameters.

## Interface
- WIDTH, 16, coefficient width (Q1.14 signed, same format as biquad)
- B0, 16'h4000, reset value of active and shadow B0
- B1, 16'h678E, reset value of active and shadow B1
- B2, 16'h4000, reset value of active and shadow B2
- A1, 16'h6473, reset value of active and shadow A1
- A2, 16'h3C38, reset value of active and shadow A2
- SETTLE, 8, samples of bypass after a swap (0 allowed), at most 255
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- smp_valid  in  1  one-cycle strobe, a new sample enters the biquad this cycle
- cfg_wr  in  1  shadow write strobe
- cfg_addr  in  3  0=B0 1=B1 2=B2 3=A1 4=A2; 5..7 are not used
- cfg_data  in  WIDTH  write data
- cfg_commit  in  1  request swap of shadow bank into active bank
- cfg_busy  out  1  commit in progress; writes and commits are rejected
- cfg_err  out  1  one-cycle pulse when a write or commit is rejected
- commit_done  out  1  one-cycle pulse when settling completes
- coef_b0, coef_b1, coef_b2, coef_a1, coef_a2  out  WIDTH each  active coefficients, registered
- filt_clr  out  1  one-cycle synchronous clear of biquad delay state
- bypass  out  1  selects data_in in place of filter output downstream

## Operation
- FSM has four states: IDLE, PEND, CLEAR, SETTLE.
- In IDLE, cfg_wr writes cfg_data into the shadow register selected by cfg_addr. Writes to addr 5..7 are ignored silently, with no cfg_err.
- In IDLE, cfg_commit moves the FSM to PEND.
- If cfg_wr and cfg_commit are both high in the same IDLE cycle, the write lands first and is part of the commit.
- In PEND, the first cycle with smp_valid=1 does two things on that edge: all five active registers load the shadow bank, and the FSM goes to CLEAR.
  - The sample strobed in that cycle is processed with the old coefficients.
- CLEAR lasts exactly one cycle. filt_clr=1 and bypass=1.
  - Next state is SETTLE if SETTLE>0, otherwise IDLE.
- In SETTLE, bypass=1. An 8-bit counter counts smp_valid pulses. The edge of the SETTLE-th pulse returns the FSM to IDLE, and commit_done pulses in the following cycle.
  - When SETTLE=0, commit_done pulses in the cycle after CLEAR.
- cfg_busy is 1 in PEND, CLEAR and SETTLE, and 0 in IDLE.
- A cfg_wr or cfg_commit arriving while cfg_busy=1 is dropped. It produces a cfg_err pulse the next cycle, and the shadow and active banks are unchanged.
- The shadow bank persists across commits. A commit with no intervening writes re-applies the same values, with the clear and settle sequence still performed.
- All arithmetic is plain register storage: no sign extension, no saturation.

## Timing
- Reset values:
  - FSM = IDLE.
  - Active and shadow banks = parameter values.
  - cfg_busy, cfg_err, commit_done, filt_clr, bypass = 0.
  - Settle counter = 0.
- Reset is asynchronous. Asserting it mid-sequence (PEND, CLEAR or SETTLE) returns every register to its reset value immediately, which restores the parameter coefficients. Any commit in progress is lost.
- cfg_busy rises one cycle after the accepted commit edge.
- Latency from commit to coefficient swap is the number of cycles until the next smp_valid, with a minimum of 1 cycle.
- Active coefficients change on the smp_valid edge in PEND. filt_clr is high in the immediately following cycle.
- bypass is high from the first CLEAR cycle up to and including the cycle of the final counted smp_valid. It deasserts on that same edge, together with cfg_busy.
- A smp_valid arriving during the CLEAR cycle is not counted toward SETTLE.
- smp_valid held high for consecutive cycles counts once per cycle.

## Test plan
- Reset with no traffic: coef_b0..a2 = 4000/678E/4000/6473/3C38, and bypass, cfg_busy and filt_clr are all 0.
- Write addr 3 = 16'h5000, then commit. smp_valid arrives 5 cycles later, then every 4 cycles, with SETTLE=8.
  - coef_a1 = 5000 the cycle after the first strobe, with filt_clr high for that one cycle.
  - bypass is high for 8 counted strobes.
  - commit_done pulses once, and cfg_busy falls on the 8th strobe edge.
- Same-cycle cfg_wr (addr 0, 16'h2000) and cfg_commit: after the swap, coef_b0 = 2000 and the other four coefficients are unchanged.
- During SETTLE, issue cfg_wr (addr 1, 16'h1111) and cfg_commit: cfg_err pulses twice, coef_b1 and the shadow bank are unchanged, and the sequence completes normally.
- Assert rst_n low in the middle of SETTLE after committing A2 = 16'h0100: coef_a2 returns to 3C38, bypass = 0 and cfg_busy = 0 asynchronously.
- With SETTLE=0, commit, then send a single strobe: filt_clr for 1 cycle, bypass for that cycle only, and commit_done in the next cycle.
